// File: rtl/seg_pkg.sv
// Seven-segment glyph patterns shared by the display encoder and the capture
// decoder. Bit order is {a,b,c,d,e,f,g}, active-high.
package seg_pkg;

  localparam logic [6:0] SEG_0     = 7'b1111110;
  localparam logic [6:0] SEG_1     = 7'b0110000;
  localparam logic [6:0] SEG_2     = 7'b1101101;
  localparam logic [6:0] SEG_3     = 7'b1111001;
  localparam logic [6:0] SEG_4     = 7'b0110011;
  localparam logic [6:0] SEG_5     = 7'b1011011;
  localparam logic [6:0] SEG_6     = 7'b1011111;
  localparam logic [6:0] SEG_7     = 7'b1110000;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1111011;
  localparam logic [6:0] SEG_A     = 7'b1110111;
  localparam logic [6:0] SEG_B     = 7'b0011111;
  localparam logic [6:0] SEG_C     = 7'b1001110;
  localparam logic [6:0] SEG_D     = 7'b0111101;
  localparam logic [6:0] SEG_E     = 7'b1001111;
  localparam logic [6:0] SEG_F     = 7'b1000111;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

endpackage

// File: rtl/seg7_decode.sv
// Combinational seven-segment pattern decoder. Hex glyphs A-F are only
// accepted when use_hex is set; all-off segments report blank.
module seg7_decode
  import seg_pkg::*;
(
  input  logic [6:0] segments,
  input  logic       use_hex,
  output logic [3:0] value,
  output logic       known,
  output logic       blank
);

  logic [3:0] glyph_s;
  logic       hit_s;
  logic       hex_only_s;

  // Lookup over the full 0-F glyph set; hex-only hits are qualified below.
  always_comb begin
    glyph_s    = 4'h0;
    hit_s      = 1'b0;
    hex_only_s = 1'b0;
    case (segments)
      SEG_0:   begin glyph_s = 4'h0; hit_s = 1'b1; end
      SEG_1:   begin glyph_s = 4'h1; hit_s = 1'b1; end
      SEG_2:   begin glyph_s = 4'h2; hit_s = 1'b1; end
      SEG_3:   begin glyph_s = 4'h3; hit_s = 1'b1; end
      SEG_4:   begin glyph_s = 4'h4; hit_s = 1'b1; end
      SEG_5:   begin glyph_s = 4'h5; hit_s = 1'b1; end
      SEG_6:   begin glyph_s = 4'h6; hit_s = 1'b1; end
      SEG_7:   begin glyph_s = 4'h7; hit_s = 1'b1; end
      SEG_8:   begin glyph_s = 4'h8; hit_s = 1'b1; end
      SEG_9:   begin glyph_s = 4'h9; hit_s = 1'b1; end
      SEG_A:   begin glyph_s = 4'hA; hit_s = 1'b1; hex_only_s = 1'b1; end
      SEG_B:   begin glyph_s = 4'hB; hit_s = 1'b1; hex_only_s = 1'b1; end
      SEG_C:   begin glyph_s = 4'hC; hit_s = 1'b1; hex_only_s = 1'b1; end
      SEG_D:   begin glyph_s = 4'hD; hit_s = 1'b1; hex_only_s = 1'b1; end
      SEG_E:   begin glyph_s = 4'hE; hit_s = 1'b1; hex_only_s = 1'b1; end
      SEG_F:   begin glyph_s = 4'hF; hit_s = 1'b1; hex_only_s = 1'b1; end
      default: begin glyph_s = 4'h0; hit_s = 1'b0; hex_only_s = 1'b0; end
    endcase
  end

  // Apply the hex enable and flag the all-off blank pattern.
  always_comb begin
    value = 4'h0;
    known = 1'b0;
    blank = 1'b0;
    if (hit_s && (use_hex || !hex_only_s)) begin
      value = glyph_s;
      known = 1'b1;
    end else begin
      value = 4'h0;
      known = 1'b0;
    end
    if (segments == SEG_BLANK) begin
      blank = 1'b1;
    end else begin
      blank = 1'b0;
    end
  end

endmodule

// File: rtl/display_capture.sv
// Captures a multiplexed seven-segment display scan into per-position
// values, publishing one complete frame once every position has been seen.
module display_capture
  import seg_pkg::*;
#(
  parameter int DIGITS  = 5,
  parameter int USE_HEX = 0,
  parameter int TIMEOUT = 1_000_000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                seg_clk,
  input  logic [7:0]          segments,
  input  logic [DIGITS-1:0]   cathodes,
  output logic [4*DIGITS-1:0] digits,
  output logic [DIGITS-1:0]   digit_valid,
  output logic [DIGITS-1:0]   dp,
  output logic                frame_valid,
  output logic                frame_error,
  output logic                err_cat,
  output logic                timeout
);

  localparam int                IW        = $clog2(TIMEOUT + 1);
  localparam logic [IW-1:0]     IDLE_LAST = IW'(TIMEOUT - 1);
  localparam logic [DIGITS-1:0] NONE      = {DIGITS{1'b0}};
  localparam logic [DIGITS-1:0] ALL_SEEN  = {DIGITS{1'b1}};
  localparam logic              HEX_EN    = (USE_HEX != 0);

  function automatic logic is_one_hot(input logic [DIGITS-1:0] v);
    return (v != NONE) && ((v & (v - DIGITS'(1))) == NONE);
  endfunction

  logic                seg_r;
  logic                event_s;
  logic                sel_ok_s;
  logic                take_s;
  logic                unknown_s;
  logic [DIGITS-1:0]   sel_s;
  logic [3:0]          dec_value_s;
  logic                dec_known_s;
  logic                dec_blank_s;
  logic [4*DIGITS-1:0] stage_digits_r, stage_digits_s;
  logic [DIGITS-1:0]   stage_valid_r, stage_valid_s;
  logic [DIGITS-1:0]   stage_dp_r, stage_dp_s;
  logic [DIGITS-1:0]   seen_r, seen_s;
  logic                err_r, err_s;
  logic [IW-1:0]       idle_r;

  assign event_s   = seg_clk & ~seg_r;
  assign sel_s     = ~cathodes;
  assign sel_ok_s  = is_one_hot(sel_s);
  assign take_s    = event_s & sel_ok_s;
  assign unknown_s = ~dec_known_s & ~dec_blank_s;

  seg7_decode u_decode (
    .segments (segments[7:1]),
    .use_hex  (HEX_EN),
    .value    (dec_value_s),
    .known    (dec_known_s),
    .blank    (dec_blank_s)
  );

  // Staging buffer and seen/error state as they stand after this sample.
  always_comb begin
    stage_digits_s = stage_digits_r;
    stage_valid_s  = stage_valid_r;
    stage_dp_s     = stage_dp_r;
    seen_s         = seen_r;
    err_s          = err_r;
    for (int i = 0; i < DIGITS; i++) begin
      if (take_s && sel_s[i]) begin
        stage_digits_s[4*i +: 4] = dec_value_s;
        stage_valid_s[i]         = dec_known_s;
        stage_dp_s[i]            = segments[0];
      end else begin
        stage_digits_s[4*i +: 4] = stage_digits_r[4*i +: 4];
        stage_valid_s[i]         = stage_valid_r[i];
        stage_dp_s[i]            = stage_dp_r[i];
      end
    end
    if (take_s) begin
      seen_s = seen_r | sel_s;
      err_s  = err_r | unknown_s;
    end else begin
      seen_s = seen_r;
      err_s  = err_r;
    end
  end

  // Edge detect, frame publish and stall watchdog; a sample beats a timeout.
  always_ff @(posedge clk) begin
    if (reset) begin
      seg_r          <= 1'b0;
      idle_r         <= {IW{1'b0}};
      seen_r         <= NONE;
      err_r          <= 1'b0;
      stage_digits_r <= {(4*DIGITS){1'b0}};
      stage_valid_r  <= NONE;
      stage_dp_r     <= NONE;
      digits         <= {(4*DIGITS){1'b0}};
      digit_valid    <= NONE;
      dp             <= NONE;
      frame_valid    <= 1'b0;
      frame_error    <= 1'b0;
      err_cat        <= 1'b0;
      timeout        <= 1'b0;
    end else begin
      seg_r          <= seg_clk;
      stage_digits_r <= stage_digits_s;
      stage_valid_r  <= stage_valid_s;
      stage_dp_r     <= stage_dp_s;
      frame_valid    <= 1'b0;
      frame_error    <= 1'b0;
      err_cat        <= 1'b0;
      timeout        <= 1'b0;
      if (event_s) begin
        idle_r <= {IW{1'b0}};
        if (!sel_ok_s) begin
          err_cat <= 1'b1;
        end else if (seen_s == ALL_SEEN) begin
          digits      <= stage_digits_s;
          digit_valid <= stage_valid_s;
          dp          <= stage_dp_s;
          frame_valid <= 1'b1;
          frame_error <= err_s;
          seen_r      <= NONE;
          err_r       <= 1'b0;
        end else begin
          seen_r <= seen_s;
          err_r  <= err_s;
        end
      end else if (idle_r == IDLE_LAST) begin
        timeout <= 1'b1;
        idle_r  <= {IW{1'b0}};
        seen_r  <= NONE;
        err_r   <= 1'b0;
      end else begin
        idle_r <= idle_r + IW'(1);
      end
    end
  end

endmodule

// File: tb/tb_display_capture.sv
// Bench for display_capture: two instances (decimal and hex) driven by the
// same directed and random scan, checked every cycle against a frame model.
module tb_display_capture;

  localparam int ND = 5;
  localparam int TO = 16;

  logic          clk;
  logic          reset;
  logic          seg_clk;
  logic [7:0]    segments;
  logic [ND-1:0] cathodes;
  logic [19:0]   digits0, digits1;
  logic [4:0]    valid0, valid1, dp0, dp1;
  logic          fv0, fv1, fe0, fe1, ec0, ec1, to0, to1;
  logic [33:0]   obs0, obs1;

  int n_checks = 0;
  int n_pass   = 0;

  // Model state, one slot per instance (0 = decimal only, 1 = hex enabled).
  logic [19:0] e_digits [2];
  logic [4:0]  e_valid  [2];
  logic [4:0]  e_dp     [2];
  bit          e_fv [2], e_fe [2], e_ec [2], e_to [2];
  logic [3:0]  st_val   [2][ND];
  bit          st_known [2][ND];
  bit          st_dp    [2][ND];
  bit          seen     [2][ND];
  bit          m_err [2], prev_seg [2];
  int          m_idle [2];

  int fv_cnt [2], ec_cnt [2], to_cnt [2];
  bit last_fe [2];

  display_capture #(.DIGITS(ND), .USE_HEX(0), .TIMEOUT(TO)) dut0 (
    .clk(clk), .reset(reset), .seg_clk(seg_clk), .segments(segments),
    .cathodes(cathodes), .digits(digits0), .digit_valid(valid0), .dp(dp0),
    .frame_valid(fv0), .frame_error(fe0), .err_cat(ec0), .timeout(to0)
  );

  display_capture #(.DIGITS(ND), .USE_HEX(1), .TIMEOUT(TO)) dut1 (
    .clk(clk), .reset(reset), .seg_clk(seg_clk), .segments(segments),
    .cathodes(cathodes), .digits(digits1), .digit_valid(valid1), .dp(dp1),
    .frame_valid(fv1), .frame_error(fe1), .err_cat(ec1), .timeout(to1)
  );

  assign obs0 = {digits0, valid0, dp0, fv0, fe0, ec0, to0};
  assign obs1 = {digits1, valid1, dp1, fv1, fe1, ec1, to1};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] glyph(input int v);
    case (v)
      0:  return 7'b1111110;
      1:  return 7'b0110000;
      2:  return 7'b1101101;
      3:  return 7'b1111001;
      4:  return 7'b0110011;
      5:  return 7'b1011011;
      6:  return 7'b1011111;
      7:  return 7'b1110000;
      8:  return 7'b1111111;
      9:  return 7'b1111011;
      10: return 7'b1110111;
      11: return 7'b0011111;
      12: return 7'b1001110;
      13: return 7'b0111101;
      14: return 7'b1001111;
      15: return 7'b1000111;
      default: return 7'b0000000;
    endcase
  endfunction

  // Returns {unknown, known, value}.
  function automatic logic [5:0] mdecode(input logic [6:0] p, input bit hex);
    logic [5:0] r;
    r = {(p != 7'h00), 1'b0, 4'h0};
    for (int j = 0; j < (hex ? 16 : 10); j++)
      if (p == glyph(j)) r = {1'b0, 1'b1, 4'(j)};
    return r;
  endfunction

  task automatic check(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s dut%0d: got %0h expected %0h", name, k, act, exp);
  endtask

  task automatic model_reset(input int k);
    e_digits[k] = 20'h0; e_valid[k] = 5'h0; e_dp[k] = 5'h0;
    e_fv[k] = 1'b0; e_fe[k] = 1'b0; e_ec[k] = 1'b0; e_to[k] = 1'b0;
    for (int i = 0; i < ND; i++) begin
      st_val[k][i] = 4'h0; st_known[k][i] = 1'b0; st_dp[k][i] = 1'b0; seen[k][i] = 1'b0;
    end
    m_err[k] = 1'b0; prev_seg[k] = 1'b0; m_idle[k] = 0;
  endtask

  // Advance the model by one clock using the inputs that the next edge samples.
  task automatic model_step(input int k);
    int ones, pos;
    logic [5:0] d;
    bit all;
    e_fv[k] = 1'b0; e_ec[k] = 1'b0; e_to[k] = 1'b0;
    if (reset) begin
      model_reset(k);
      return;
    end
    if (seg_clk && !prev_seg[k]) begin
      m_idle[k] = 0;
      ones = 0; pos = 0;
      for (int i = 0; i < ND; i++) if (!cathodes[i]) begin ones++; pos = i; end
      if (ones != 1) begin
        e_ec[k] = 1'b1;
      end else begin
        d = mdecode(segments[7:1], k == 1);
        st_val[k][pos] = d[3:0]; st_known[k][pos] = d[4]; st_dp[k][pos] = segments[0];
        seen[k][pos] = 1'b1;
        if (d[5]) m_err[k] = 1'b1;
        all = 1'b1;
        for (int i = 0; i < ND; i++) if (!seen[k][i]) all = 1'b0;
        if (all) begin
          for (int i = 0; i < ND; i++) begin
            e_digits[k][4*i +: 4] = st_val[k][i];
            e_valid[k][i] = st_known[k][i];
            e_dp[k][i] = st_dp[k][i];
            seen[k][i] = 1'b0;
          end
          e_fv[k] = 1'b1; e_fe[k] = m_err[k]; m_err[k] = 1'b0;
        end
      end
    end else begin
      m_idle[k]++;
      if (m_idle[k] == TO) begin
        e_to[k] = 1'b1; m_idle[k] = 0; m_err[k] = 1'b0;
        for (int i = 0; i < ND; i++) seen[k][i] = 1'b0;
      end
    end
    prev_seg[k] = seg_clk;
  endtask

  // Per-cycle comparison against the model, then model advance.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      logic [33:0] o;
      o = (k == 0) ? obs0 : obs1;
      check("digits", k, 32'(o[33:14]), 32'(e_digits[k]));
      check("digit_valid", k, 32'(o[13:9]), 32'(e_valid[k]));
      check("dp", k, 32'(o[8:4]), 32'(e_dp[k]));
      check("frame_valid", k, 32'(o[3]), 32'(e_fv[k]));
      if (e_fv[k]) check("frame_error", k, 32'(o[2]), 32'(e_fe[k]));
      check("err_cat", k, 32'(o[1]), 32'(e_ec[k]));
      check("timeout", k, 32'(o[0]), 32'(e_to[k]));
      if (o[3] === 1'b1) begin fv_cnt[k]++; last_fe[k] = o[2]; end
      if (o[1] === 1'b1) ec_cnt[k]++;
      if (o[0] === 1'b1) to_cnt[k]++;
      model_step(k);
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #2;
  endtask

  task automatic sample_raw(input logic [ND-1:0] cath, input logic [7:0] seg);
    cathodes = cath; segments = seg; seg_clk = 1'b1;
    next_cycle();
    seg_clk = 1'b0;
    next_cycle();
  endtask

  task automatic sample(input int pos, input logic [6:0] pat, input logic dpb);
    logic [ND-1:0] one;
    one = 5'b00001;
    sample_raw(~(one << pos), {pat, dpb});
  endtask

  task automatic wait_idle(input int n);
    seg_clk = 1'b0;
    repeat (n) next_cycle();
  endtask

  int b_fv0, b_fv1, b_ec0, b_to0, b_to1;
  logic [6:0] rp;
  int idx;

  initial begin
    model_reset(0); model_reset(1);
    reset = 1'b1; seg_clk = 1'b0; cathodes = 5'b11111; segments = 8'h00;
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    check("rst_digits", 0, 32'(digits0), 32'h0);
    check("rst_flags", 1, 32'({valid1, dp1, fv1, ec1, to1}), 32'h0);

    // Basic frame 1..5 with dp on positions 1 and 3.
    b_fv0 = fv_cnt[0]; b_fv1 = fv_cnt[1];
    sample(0, glyph(1), 1'b0); sample(1, glyph(2), 1'b1); sample(2, glyph(3), 1'b0);
    sample(3, glyph(4), 1'b1); sample(4, glyph(5), 1'b0);
    check("basic_digits", 0, 32'(digits0), 32'h54321);
    check("basic_digits", 1, 32'(digits1), 32'h54321);
    check("basic_valid", 0, 32'(valid0), 32'h1f);
    check("basic_dp", 0, 32'(dp0), 32'h0a);
    check("basic_fe", 0, 32'(last_fe[0]), 32'h0);
    check("basic_frames", 0, 32'(fv_cnt[0] - b_fv0), 32'd1);
    check("basic_frames", 1, 32'(fv_cnt[1] - b_fv1), 32'd1);
    check("model_basic", 0, 32'(e_digits[0]), 32'h54321);

    // Two cathodes low: discarded sample, err_cat pulse.
    b_ec0 = ec_cnt[0]; b_fv0 = fv_cnt[0];
    sample_raw(5'b11100, {glyph(7), 1'b0});
    check("cat_err", 0, 32'(ec_cnt[0] - b_ec0), 32'd1);
    sample(2, glyph(9), 1'b0); sample(3, glyph(9), 1'b0); sample(4, glyph(9), 1'b0);
    check("cat_noseen", 0, 32'(fv_cnt[0] - b_fv0), 32'd0);
    sample(0, glyph(8), 1'b0); sample(1, glyph(8), 1'b0);
    check("cat_frame", 0, 32'(fv_cnt[0] - b_fv0), 32'd1);
    check("cat_digits", 0, 32'(digits0), 32'h99988);

    // Unknown pattern at position 2.
    sample(0, glyph(1), 1'b0); sample(1, glyph(2), 1'b0); sample(2, 7'b1000001, 1'b0);
    sample(3, glyph(4), 1'b0); sample(4, glyph(5), 1'b0);
    check("unk_fe", 0, 32'(last_fe[0]), 32'h1);
    check("unk_valid", 0, 32'(valid0), 32'h1b);
    check("unk_digits", 0, 32'(digits0), 32'h54021);

    // Hex glyph A at position 0: unknown without hex, 4'hA with hex.
    sample(0, 7'b1110111, 1'b0); sample(1, glyph(1), 1'b0); sample(2, glyph(2), 1'b0);
    sample(3, glyph(3), 1'b0); sample(4, glyph(4), 1'b0);
    check("hex_off_fe", 0, 32'(last_fe[0]), 32'h1);
    check("hex_off_digits", 0, 32'(digits0), 32'h43210);
    check("hex_off_valid", 0, 32'(valid0), 32'h1e);
    check("hex_on_fe", 1, 32'(last_fe[1]), 32'h0);
    check("hex_on_digits", 1, 32'(digits1), 32'h4321a);
    check("hex_on_valid", 1, 32'(valid1), 32'h1f);

    // Stall after a partial frame, then a fresh frame in rotated order.
    b_to0 = to_cnt[0]; b_to1 = to_cnt[1];
    sample(0, glyph(3), 1'b1); sample(1, glyph(3), 1'b1); sample(2, glyph(3), 1'b1);
    wait_idle(20);
    check("stall_timeout", 0, 32'(to_cnt[0] - b_to0), 32'd1);
    check("stall_timeout", 1, 32'(to_cnt[1] - b_to1), 32'd1);
    b_fv0 = fv_cnt[0];
    sample(3, glyph(9), 1'b0); sample(4, glyph(0), 1'b0); sample(0, glyph(6), 1'b0);
    sample(1, glyph(7), 1'b0); sample(2, glyph(8), 1'b0);
    check("stall_frames", 0, 32'(fv_cnt[0] - b_fv0), 32'd1);
    check("stall_digits", 0, 32'(digits0), 32'h09876);
    check("stall_dp", 0, 32'(dp0), 32'h00);

    // Reset mid-frame discards the partial frame.
    sample(0, glyph(1), 1'b1); sample(1, glyph(1), 1'b1); sample(2, glyph(1), 1'b1); sample(3, glyph(1), 1'b1);
    reset = 1'b1;
    next_cycle(); next_cycle();
    reset = 1'b0;
    check("midrst_out", 0, 32'({digits0, valid0, dp0}), 32'h0);
    check("midrst_out", 1, 32'({digits1, valid1, dp1}), 32'h0);
    b_fv0 = fv_cnt[0];
    for (int p = 0; p < ND; p++) sample(p, glyph(p + 5), 1'b0);
    check("midrst_frames", 0, 32'(fv_cnt[0] - b_fv0), 32'd1);

    // Random scan traffic.
    for (int c = 0; c < 1500; c++) begin
      reset = ($urandom_range(0, 79) == 0);
      seg_clk = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) != 0) cathodes = ~(5'b00001 << $urandom_range(0, 4));
      else cathodes = 5'($urandom);
      if ($urandom_range(0, 3) != 0) begin
        idx = $urandom_range(0, 16);
        rp = glyph(idx);
      end else begin
        rp = 7'($urandom);
      end
      segments = {rp, 1'($urandom)};
      next_cycle();
      if ($urandom_range(0, 99) == 0) wait_idle(TO + 2);
    end
    reset = 1'b0; seg_clk = 1'b0;
    repeat (4) next_cycle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
